clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Runs in the PLL output clock domain, downstream of the PLL wrapper.
- Filters the raw PLL lock, sequences a clean downstream reset, then generates CHANNELS phase-aligned clock-enable strobes with runtime-programmable divisors.
- Replaces ad-hoc per-module dividers; consumers run on the single PLL clock and gate logic with ce[i].

Parameters:
CHANNELS, 4, number of clock-enable channels (1..16)
CNT_W, 16, divisor/counter width per channel (2..32)
LOCK_STABLE, 1024, cycles synchronised lock must stay high before reset sequencing (>=1)
RST_HOLD, 16, cycles sys_resetn is held low after lock is stable (>=1)
DIV_DEFAULT, 1, divisor loaded into every channel on reset

Ports:
clock_in  input  1  block clock (PLL output clock)
resetn  input  1  asynchronous active-low reset
pll_locked  input  1  raw PLL lock, asynchronous to clock_in
div_cfg  input  CHANNELS*CNT_W  divisor for channel i at [i*CNT_W +: CNT_W]
div_load  input  1  single-cycle strobe: latch div_cfg
lost_clr  input  1  single-cycle strobe: clear lock_lost
sys_resetn  output  1  downstream reset, active-low, registered
ready  output  1  high while in RUN, registered
ce  output  CHANNELS  one-cycle clock-enable strobes, registered
lock_lost  output  1  sticky: lock dropped while in RUN

Behaviour:
- Reset (resetn=0, async):
  - state=WAIT_LOCK; all counters 0; divisors=DIV_DEFAULT.
  - sys_resetn=0, ready=0, ce=0, lock_lost=0.
- Lock sync: pll_locked passes through a 2-flop synchroniser to give locked_s. Synchroniser flops reset to 0.
- FSM states:
  - WAIT_LOCK: on an edge with locked_s=1, go to STABLE with stable_cnt=0.
  - STABLE: stable_cnt increments every cycle. After LOCK_STABLE cycles in STABLE, go to HOLD.
  - HOLD: lasts exactly RST_HOLD cycles, then RUN.
  - RUN: stays in RUN while locked_s=1.
- Lock drop: locked_s=0 in STABLE, HOLD or RUN returns to WAIT_LOCK on that edge.
  - stable_cnt, hold counter and all channel counters clear.
  - From RUN, lock_lost sets on the same edge.
- Outputs by state:
  - sys_resetn=1 and ready=1 only in RUN; both 0 in all other states.
  - ce=0 outside RUN.
- Latency: pll_locked first sampled high at edge k gives ready=1 after edge k+2+LOCK_STABLE+RST_HOLD.
- Dividers:
  - Channel i has counter cnt_i (CNT_W bits), held at 0 outside RUN. In RUN, the first RUN cycle is phase index 0.
  - If D_i >= 2: cnt_i counts 0..D_i-1 and wraps. ce[i]=1 exactly in cycles where cnt_i==D_i-1, so one pulse every D_i cycles and the first pulse falls in RUN cycle D_i-1.
  - If D_i is 0 or 1: ce[i]=1 every RUN cycle.
- div_load:
  - On a div_load edge, all divisor registers take div_cfg.
  - If in RUN, all cnt_i reset to 0 on that same edge, so channels stay phase-aligned. The next cycle is phase index 0, and ce is 0 in that cycle unless the new D<=1.
  - div_load outside RUN updates divisors only.
  - div_load coincident with a lock drop: divisors update, FSM still leaves RUN.
- lock_lost: set wins over lost_clr on the same edge. Cleared only by lost_clr or resetn.
- Reset mid-operation: resetn assertion immediately forces all reset values, including divisors.

Optional Feature:
CLKEN_DROP_COUNT_EN
- Defined:
  - Adds output lock_drops [7:0], reset 0.
  - Increments, saturating at 255, on every edge where locked_s falls while in STABLE, HOLD or RUN.
  - Cleared by lost_clr. A drop on the same edge as lost_clr yields 1.
- Undefined: port absent; no counter logic.

Test Plan:
- Params CHANNELS=2, LOCK_STABLE=8, RST_HOLD=4. Release resetn, pll_locked=1 before edge 0 -> sys_resetn/ready rise after edge 14, ce=0 before that.
- Same setup with pll_locked pulsed low for 3 cycles at STABLE cycle 5 -> FSM returns to WAIT_LOCK, stable count restarts, ready delayed accordingly, lock_lost stays 0.
- In RUN with div_cfg={D1=5,D0=1}, div_load pulse -> ce[0] high every cycle; ce[1] high in cycles 4, 9, 14 after the load edge+1.
- In RUN, D0=3, reload D0=4 at mid-count -> ce[0] first pulses 3 cycles after the phase-0 cycle, then every 4.
- In RUN, drop pll_locked -> 2 cycles later ready=0, sys_resetn=0, ce=0, lock_lost=1. lost_clr coincident with a second drop -> lock_lost stays 1.
- With CLKEN_DROP_COUNT_EN: 300 lock drops in RUN/STABLE -> lock_drops=255; lost_clr -> 0.

Source files
------------

// File: rtl/clk_enable_gen.sv
// PLL lock filter, downstream reset sequencer and phase-aligned clock-enable generator.
// Define CLKEN_DROP_COUNT_EN to add the saturating lock_drops counter output.
module clk_enable_gen #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned DIV_DEFAULT = 1
) (
    input  logic                      clock_in,
    input  logic                      resetn,
    input  logic                      pll_locked,
    input  logic [CHANNELS*CNT_W-1:0] div_cfg,
    input  logic                      div_load,
    input  logic                      lost_clr,
    output logic                      sys_resetn,
    output logic                      ready,
    output logic [CHANNELS-1:0]       ce,
    output logic                      lock_lost
`ifdef CLKEN_DROP_COUNT_EN
    ,
    output logic [7:0]                lock_drops
`endif
);

    localparam int unsigned StableW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int unsigned HoldW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [StableW-1:0] StableLast = StableW'(LOCK_STABLE - 1);
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   DivOne     = CNT_W'(1);

    typedef enum logic [1:0] {StWaitLock, StStable, StHold, StRun} state_e;

    state_e             state_q;
    logic               sync_q;
    logic               locked_s;
    logic [StableW-1:0] stable_cnt_q;
    logic [HoldW-1:0]   hold_cnt_q;
    logic               lock_drop;
    logic               run_d;

    logic [CNT_W-1:0]    div_q   [CHANNELS];
    logic [CNT_W-1:0]    div_eff [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] ce_d;

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    always_comb begin
        lock_drop = (state_q != StWaitLock) && !locked_s;
        run_d     = locked_s && ((state_q == StRun) ||
                                 ((state_q == StHold) && (hold_cnt_q == HoldLast)));
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StWaitLock;
            stable_cnt_q <= '0;
            hold_cnt_q   <= '0;
            sys_resetn   <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            sys_resetn <= run_d;
            ready      <= run_d;
            // A drop out of RUN takes priority over a coincident clear.
            if ((state_q == StRun) && !locked_s) begin
                lock_lost <= 1'b1;
            end else if (lost_clr) begin
                lock_lost <= 1'b0;
            end
            if (lock_drop) begin
                state_q      <= StWaitLock;
                stable_cnt_q <= '0;
                hold_cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StWaitLock: begin
                        if (locked_s) begin
                            state_q      <= StStable;
                            stable_cnt_q <= '0;
                        end
                    end
                    StStable: begin
                        if (stable_cnt_q == StableLast) begin
                            state_q      <= StHold;
                            stable_cnt_q <= '0;
                            hold_cnt_q   <= '0;
                        end else begin
                            stable_cnt_q <= stable_cnt_q + 1'b1;
                        end
                    end
                    StHold: begin
                        if (hold_cnt_q == HoldLast) begin
                            state_q    <= StRun;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    StRun: begin
                    end
                    default: state_q <= StWaitLock;
                endcase
            end
        end
    end

    // Counters restart on RUN entry and on any load so all channels share phase 0.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            div_eff[i] = div_load ? div_cfg[i*CNT_W +: CNT_W] : div_q[i];
            if (!run_d || div_load || (state_q != StRun)) begin
                cnt_d[i] = '0;
            end else if ((div_q[i] <= DivOne) || (cnt_q[i] == div_q[i] - DivOne)) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DivOne;
            end
            ce_d[i] = run_d && ((div_eff[i] <= DivOne) || (cnt_d[i] == div_eff[i] - DivOne));
        end
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= CNT_W'(DIV_DEFAULT);
                cnt_q[i] <= '0;
            end
            ce <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (div_load) begin
                    div_q[i] <= div_cfg[i*CNT_W +: CNT_W];
                end
                cnt_q[i] <= cnt_d[i];
            end
            ce <= ce_d;
        end
    end

`ifdef CLKEN_DROP_COUNT_EN
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            lock_drops <= 8'd0;
        end else if (lost_clr) begin
            lock_drops <= {7'd0, lock_drop};
        end else if (lock_drop && (lock_drops != 8'hFF)) begin
            lock_drops <= lock_drops + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomised self-checking bench for clk_enable_gen against a lock-run-length / phase model.
// Exercises lock_drops when CLKEN_DROP_COUNT_EN is defined.
module tb_clk_enable_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned LS = 8;
    localparam int unsigned RH = 4;
    localparam int RunAt = 1 + LS + RH;

    logic            clock_in   = 1'b0;
    logic            resetn     = 1'b0;
    logic            pll_locked = 1'b0;
    logic [CH*CW-1:0] div_cfg   = '0;
    logic            div_load   = 1'b0;
    logic            lost_clr   = 1'b0;
    logic            sys_resetn;
    logic            ready;
    logic [CH-1:0]   ce;
    logic            lock_lost;
`ifdef CLKEN_DROP_COUNT_EN
    logic [7:0]      lock_drops;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: consecutive locked_s-high edges, RUN phase index, divisors, sticky flags.
    bit m_s1, m_s2, m_run, m_lost;
    int m_c, m_p, m_drops;
    int m_div [CH];

    always #5 clock_in = ~clock_in;

    clk_enable_gen #(
        .CHANNELS(CH), .CNT_W(CW), .LOCK_STABLE(LS), .RST_HOLD(RH), .DIV_DEFAULT(1)
    ) dut (
        .clock_in  (clock_in),
        .resetn    (resetn),
        .pll_locked(pll_locked),
        .div_cfg   (div_cfg),
        .div_load  (div_load),
        .lost_clr  (lost_clr),
        .sys_resetn(sys_resetn),
        .ready     (ready),
        .ce        (ce),
        .lock_lost (lock_lost)
`ifdef CLKEN_DROP_COUNT_EN
        ,
        .lock_drops(lock_drops)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0;
        m_c = 0; m_p = 0; m_drops = 0;
        for (int i = 0; i < CH; i++) m_div[i] = 1;
    endfunction

    task automatic model_edge();
        bit ls, was_run, drop;
        ls = m_s2;
        was_run = m_run;
        drop = (m_c >= 1) && !ls;
        m_c = ls ? ((m_c < RunAt) ? m_c + 1 : RunAt) : 0;
        if (was_run && !ls) m_lost = 1;
        else if (lost_clr) m_lost = 0;
        if (lost_clr) m_drops = drop ? 1 : 0;
        else if (drop && m_drops < 255) m_drops++;
        if (div_load) for (int i = 0; i < CH; i++) m_div[i] = int'(div_cfg[i*CW +: CW]);
        m_run = (m_c >= RunAt);
        if (m_run) m_p = (!was_run || div_load) ? 0 : m_p + 1;
        else m_p = 0;
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    function automatic logic [CH-1:0] exp_ce();
        logic [CH-1:0] e;
        for (int i = 0; i < CH; i++) begin
            e[i] = m_run && ((m_div[i] <= 1) || ((m_p % m_div[i]) == m_div[i] - 1));
        end
        return e;
    endfunction

    task automatic check_outputs();
        chk("sys_resetn", 32'(sys_resetn), 32'(m_run));
        chk("ready", 32'(ready), 32'(m_run));
        chk("ce", 32'(ce), 32'(exp_ce()));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
`ifdef CLKEN_DROP_COUNT_EN
        chk("lock_drops", 32'(lock_drops), 32'(m_drops));
`endif
    endtask

    // Inputs change on the falling edge; outputs are compared there too.
    task automatic tick();
        @(posedge clock_in);
        if (resetn) model_edge();
        else model_reset();
        @(negedge clock_in);
        check_outputs();
    endtask

    task automatic apply_reset(input int n);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (n) tick();
        resetn = 1'b1;
    endtask

    initial begin
        // Lock present from edge 0: ready rises after edge 14.
        apply_reset(3);
        pll_locked = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (n == 13) begin
                chk("ready_edge13", 32'(ready), 32'd0);
                chk("ce_before_run", 32'(ce), 32'd0);
            end
            if (n == 14) begin
                chk("ready_edge14", 32'(ready), 32'd1);
                chk("sys_resetn_edge14", 32'(sys_resetn), 32'd1);
            end
        end

        // D1=5, D0=1 loaded in RUN.
        div_cfg = {16'd5, 16'd1};
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("ce1_div5", 32'(ce[1]), 32'((k == 4) || (k == 9) || (k == 14)));
            chk("ce0_div1", 32'(ce[0]), 32'd1);
            tick();
        end

        // D0=3, then reload D0=4 mid-count.
        div_cfg = {16'd5, 16'd3};
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        tick();
        div_cfg = {16'd5, 16'd4};
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("ce0_reload4", 32'(ce[0]), 32'((k == 3) || (k == 7) || (k == 11)));
            tick();
        end

        // Lock drop in RUN: leaves RUN two edges after the low sample.
        pll_locked = 1'b0;
        tick();
        tick();
        chk("ready_before_exit", 32'(ready), 32'd1);
        tick();
        chk("ready_after_drop", 32'(ready), 32'd0);
        chk("sys_resetn_after_drop", 32'(sys_resetn), 32'd0);
        chk("ce_after_drop", 32'(ce), 32'd0);
        chk("lock_lost_set", 32'(lock_lost), 32'd1);
        pll_locked = 1'b1;
        repeat (20) tick();
        chk("ready_relock", 32'(ready), 32'd1);
        pll_locked = 1'b0;
        tick();
        tick();
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        chk("lost_set_beats_clr", 32'(lock_lost), 32'd1);
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        chk("lost_cleared", 32'(lock_lost), 32'd0);

        // 3-cycle lock glitch during STABLE: ready delayed to after edge 25.
        apply_reset(2);
        pll_locked = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            pll_locked = !((n + 1 >= 8) && (n + 1 <= 10));
            if (n == 24) chk("glitch_ready_edge24", 32'(ready), 32'd0);
            if (n == 25) chk("glitch_ready_edge25", 32'(ready), 32'd1);
            if (n == 29) chk("glitch_no_lost", 32'(lock_lost), 32'd0);
        end

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
            else pll_locked = ($urandom_range(0, 2) == 0);
            div_load = ($urandom_range(0, 39) == 0);
            if (div_load) begin
                for (int i = 0; i < CH; i++) div_cfg[i*CW +: CW] = CW'($urandom_range(0, 7));
            end
            lost_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                div_load = 1'b0;
                lost_clr = 1'b0;
                apply_reset(2);
            end else begin
                tick();
            end
        end
        div_load = 1'b0;
        lost_clr = 1'b0;

`ifdef CLKEN_DROP_COUNT_EN
        // 300 drops saturate the counter; lost_clr clears it.
        apply_reset(2);
        for (int n = 0; n < 600; n++) begin
            pll_locked = (n % 2 == 0);
            tick();
        end
        pll_locked = 1'b1;
        repeat (4) tick();
        chk("drops_saturated", 32'(lock_drops), 32'd255);
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        chk("drops_cleared", 32'(lock_drops), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
